// File: rtl/rv32_fetch_aligner_if.sv
`default_nettype none
// ============================================================================
// Module      : rv32_fetch_aligner_if
// Description : Handshake bundle between the fetch unit, the instruction
//               aligner and the decoder.
//               Fetch side : in_valid / in_ready / in_data
//               Decode side: out_valid / out_ready / out_instr / out_pc /
//                            out_is_compressed
//               Redirect   : flush / flush_pc
//               Modport slave is the aligner's view of the bundle; modport
//               master is the view of the surrounding fetch/decode logic.
// Revision    : 1.0 - initial release
// ============================================================================
interface rv32_fetch_aligner_if;
  logic        flush;
  logic [31:0] flush_pc;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_is_compressed;

  modport slave (
    input  flush, flush_pc, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_is_compressed
  );

  modport master (
    output flush, flush_pc, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_is_compressed
  );
endinterface
`default_nettype wire

// File: rtl/rv32_fetch_aligner.sv
`default_nettype none
// ============================================================================
// Module      : rv32_fetch_aligner
// Description : RV32IC instruction-stream aligner. Takes sequential 32-bit
//               fetch words and hands the decoder one aligned instruction
//               (16-bit compressed or 32-bit) per handshake, with its PC.
//               Ports:
//                 clk   - system clock, rising edge
//                 rst_n - asynchronous active-low reset
//                 bus   - rv32_fetch_aligner_if.slave (fetch input, decode
//                         output and redirect signals)
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  rv32_fetch_aligner_if.slave    bus
);

  // Halfword queue, head at index 0; r_pc is the address of the head.
  logic [15:0] r_hw [0:2];
  logic [1:0]  r_count;
  logic [31:0] r_pc;
  // Set when the next fetch word's low halfword precedes the target PC.
  logic        r_skip_low;

  logic        w_head_c;
  logic        w_out_valid;
  logic        w_in_ready;
  logic        w_out_fire;
  logic        w_in_fire;
  logic [1:0]  w_pop;
  logic [1:0]  w_rem;
  logic [1:0]  w_add;
  logic [15:0] w_shift  [0:2];
  logic [15:0] w_hw_nxt [0:2];
  logic [1:0]  w_count_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_flush_pc;

  // Everything the decoder and fetch unit see depends on registers only.
  assign w_head_c    = (r_hw[0][1:0] != 2'b11);
  assign w_out_valid = ((r_count != 2'd0) && w_head_c) || (r_count >= 2'd2);
  assign w_in_ready  = (r_count <= 2'd1);
  assign w_out_fire  = w_out_valid && bus.out_ready;
  assign w_in_fire   = w_in_ready && bus.in_valid;
  assign w_flush_pc  = bus.flush_pc & ~32'h1;

  assign bus.in_ready          = w_in_ready;
  assign bus.out_valid         = w_out_valid;
  assign bus.out_pc            = r_pc;
  assign bus.out_is_compressed = (r_count != 2'd0) && w_head_c;
  assign bus.out_instr         = w_head_c ? {16'h0000, r_hw[0]} : {r_hw[1], r_hw[0]};

  always_comb begin
    w_pop = 2'd0;
    if (w_out_fire) begin
      w_pop = w_head_c ? 2'd1 : 2'd2;
    end

    // Pop first: shift the queue down by the consumed halfwords.
    w_shift[0] = r_hw[0];
    w_shift[1] = r_hw[1];
    w_shift[2] = r_hw[2];
    case (w_pop)
      2'd1: begin
        w_shift[0] = r_hw[1];
        w_shift[1] = r_hw[2];
        w_shift[2] = 16'h0000;
      end
      2'd2: begin
        w_shift[0] = r_hw[2];
        w_shift[1] = 16'h0000;
        w_shift[2] = 16'h0000;
      end
      default: ;
    endcase
    w_rem = r_count - w_pop;

    // Then append behind the remaining entries. in_ready guarantees at most
    // one entry remains, so two new halfwords always fit.
    w_hw_nxt[0] = w_shift[0];
    w_hw_nxt[1] = w_shift[1];
    w_hw_nxt[2] = w_shift[2];
    w_add       = 2'd0;
    if (w_in_fire) begin
      if (r_skip_low) begin
        w_add = 2'd1;
        if (w_rem == 2'd0) begin
          w_hw_nxt[0] = bus.in_data[31:16];
        end else begin
          w_hw_nxt[1] = bus.in_data[31:16];
        end
      end else begin
        w_add = 2'd2;
        if (w_rem == 2'd0) begin
          w_hw_nxt[0] = bus.in_data[15:0];
          w_hw_nxt[1] = bus.in_data[31:16];
        end else begin
          w_hw_nxt[1] = bus.in_data[15:0];
          w_hw_nxt[2] = bus.in_data[31:16];
        end
      end
    end
    w_count_nxt = w_rem + w_add;

    // pop of 1 halfword advances by 2 bytes, pop of 2 by 4 bytes.
    w_pc_nxt = r_pc + {29'd0, w_pop, 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hw[0]    <= 16'h0000;
      r_hw[1]    <= 16'h0000;
      r_hw[2]    <= 16'h0000;
      r_count    <= 2'd0;
      r_pc       <= RESET_PC;
      r_skip_low <= RESET_PC[1];
    end else if (bus.flush) begin
      // Redirect wins over both handshakes in the same cycle.
      r_hw[0]    <= 16'h0000;
      r_hw[1]    <= 16'h0000;
      r_hw[2]    <= 16'h0000;
      r_count    <= 2'd0;
      r_pc       <= w_flush_pc;
      r_skip_low <= w_flush_pc[1];
    end else begin
      r_hw[0]    <= w_hw_nxt[0];
      r_hw[1]    <= w_hw_nxt[1];
      r_hw[2]    <= w_hw_nxt[2];
      r_count    <= w_count_nxt;
      r_pc       <= w_pc_nxt;
      if (w_in_fire) begin
        r_skip_low <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
